// File: rtl/pkt_pkg.sv
// -----------------------------------------------------------------------------
// pkt_pkg
// Definitions shared by the packet deframer and the packet packer.
//   - pkt_type_e  : 3-bit packet type carried in header bits [2:0]
//   - dfr_state_e : deframer FSM states (exported on the deframer debug port)
//   - PKT_WORDS   : words per packet (9 with PKT_DEFRAMER_CHECKSUM_EN, else 8)
//   - FLD_*       : word index of each field inside a packet
// Configuration macro: PKT_DEFRAMER_CHECKSUM_EN adds a trailing XOR word.
// -----------------------------------------------------------------------------
package pkt_pkg;

    typedef enum logic [2:0] {
        PT_HB      = 3'b000,
        PT_CHE     = 3'b001,
        PT_INV     = 3'b010,
        PT_MR      = 3'b011,
        PT_ACK     = 3'b100,
        PT_DATA    = 3'b101,
        PT_SOS     = 3'b110,
        PT_INVALID = 3'b111
    } pkt_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_HOLD = 2'd2
    } dfr_state_e;

    localparam logic [15:0] BROADCAST_ID_DEF = 16'hFFFF;

`ifdef PKT_DEFRAMER_CHECKSUM_EN
    localparam int PKT_WORDS = 9;
`else
    localparam int PKT_WORDS = 8;
`endif

    // Word counter must reach PKT_WORDS-1.
    localparam int CNT_W     = (PKT_WORDS > 8) ? 4 : 3;
    localparam int LAST_WORD = PKT_WORDS - 1;

    localparam int FLD_HEADER   = 0;
    localparam int FLD_SOURCE   = 1;
    localparam int FLD_ENERGY   = 2;
    localparam int FLD_QVALUE   = 3;
    localparam int FLD_SRC_HOPS = 4;
    localparam int FLD_DEST     = 5;
    localparam int FLD_CH       = 6;
    localparam int FLD_HOPS_CH  = 7;
    localparam int FLD_CHECKSUM = 8;

endpackage

// File: rtl/pkt_accept_filter.sv
// -----------------------------------------------------------------------------
// pkt_accept_filter
// Combinational accept decision for a received packet.
//   pkt_type_i [2:0]  packet type from the header
//   dest_id_i  [W]    destination ID field
//   my_id_i    [W]    own node ID
//   accept_o          1 = packet is for this node
// HB/CHE/INV are always accepted, MR/ACK/DATA/SOS only when addressed to this
// node or to the broadcast ID, and the INVALID type never.
// -----------------------------------------------------------------------------
module pkt_accept_filter
    import pkt_pkg::*;
#(
    parameter int                    WORD_WIDTH   = 16,
    parameter logic [WORD_WIDTH-1:0] BROADCAST_ID = BROADCAST_ID_DEF
) (
    input  logic [2:0]            pkt_type_i,
    input  logic [WORD_WIDTH-1:0] dest_id_i,
    input  logic [WORD_WIDTH-1:0] my_id_i,
    output logic                  accept_o
);

    logic addressed;

    assign addressed = (dest_id_i == my_id_i) || (dest_id_i == BROADCAST_ID);

    always_comb begin
        accept_o = 1'b0;
        case (pkt_type_e'(pkt_type_i))
            PT_HB, PT_CHE, PT_INV:          accept_o = 1'b1;
            PT_MR, PT_ACK, PT_DATA, PT_SOS: accept_o = addressed;
            default:                        accept_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pkt_deframer.sv
// -----------------------------------------------------------------------------
// pkt_deframer
// Collects a word stream into a packet, filters it and presents the parsed
// fields until the consumer takes them.
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   en                        block enable (0 aborts a packet in reception)
//   myNodeID                  own node ID
//   rx_data/rx_valid/rx_sof   word stream in, rx_sof marks the header word
//   rx_ready                  word accepted (1 when enabled and not holding)
//   pkt_valid/pkt_ready       parsed packet out
//   fPacketType..fHopsFromCH  parsed fields, updated only on acceptance
//   iAmDestination            held destination equals myNodeID
//   drop_count                saturating count of dropped packets
//   dbg_state                 FSM state (dfr_state_e encoding)
// Handshakes: a word moves when rx_valid && rx_ready on a rising edge; a packet
// is consumed when pkt_valid && pkt_ready on a rising edge. pkt_ready has no
// effect while pkt_valid is low.
// Configuration macro: PKT_DEFRAMER_CHECKSUM_EN -> 9-word packets whose last
// word must equal the XOR of words 0-7.
// -----------------------------------------------------------------------------
module pkt_deframer
    import pkt_pkg::*;
#(
    parameter int                    WORD_WIDTH   = 16,
    parameter logic [WORD_WIDTH-1:0] BROADCAST_ID = BROADCAST_ID_DEF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_sof,
    output logic                  rx_ready,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [2:0]            fPacketType,
    output logic [WORD_WIDTH-1:0] fSourceID,
    output logic [WORD_WIDTH-1:0] fEnergyLeft,
    output logic [WORD_WIDTH-1:0] fQValue,
    output logic [WORD_WIDTH-1:0] fSourceHops,
    output logic [WORD_WIDTH-1:0] fDestinationID,
    output logic [WORD_WIDTH-1:0] fChosenCH,
    output logic [WORD_WIDTH-1:0] fHopsFromCH,
    output logic                  iAmDestination,
    output logic [7:0]            drop_count,
    output logic [1:0]            dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_WORD);

    dfr_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Shadow registers for the packet in reception.
    logic [2:0]            sh_type_q, sh_type_d;
    logic [WORD_WIDTH-1:0] sh_src_q, sh_src_d;
    logic [WORD_WIDTH-1:0] sh_energy_q, sh_energy_d;
    logic [WORD_WIDTH-1:0] sh_qval_q, sh_qval_d;
    logic [WORD_WIDTH-1:0] sh_shops_q, sh_shops_d;
    logic [WORD_WIDTH-1:0] sh_dest_q, sh_dest_d;
    logic [WORD_WIDTH-1:0] sh_ch_q, sh_ch_d;
`ifdef PKT_DEFRAMER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] sh_hch_q, sh_hch_d;
    logic [WORD_WIDTH-1:0] csum_q, csum_d;
`endif

    // Presented fields.
    logic [2:0]            f_type_q, f_type_d;
    logic [WORD_WIDTH-1:0] f_src_q, f_src_d;
    logic [WORD_WIDTH-1:0] f_energy_q, f_energy_d;
    logic [WORD_WIDTH-1:0] f_qval_q, f_qval_d;
    logic [WORD_WIDTH-1:0] f_shops_q, f_shops_d;
    logic [WORD_WIDTH-1:0] f_dest_q, f_dest_d;
    logic [WORD_WIDTH-1:0] f_ch_q, f_ch_d;
    logic [WORD_WIDTH-1:0] f_hch_q, f_hch_d;
    logic                  iam_q, iam_d;
    logic [7:0]            drop_q, drop_d;

    logic                  xfer;
    logic                  drop_inc;
    logic                  filter_ok;
    logic                  final_ok;
    logic [WORD_WIDTH-1:0] hops_ch_final;

    assign rx_ready = en && (state_q != S_HOLD);
    assign xfer     = rx_valid && rx_ready;

    pkt_accept_filter #(
        .WORD_WIDTH  (WORD_WIDTH),
        .BROADCAST_ID(BROADCAST_ID)
    ) u_filter (
        .pkt_type_i(sh_type_q),
        .dest_id_i (sh_dest_q),
        .my_id_i   (myNodeID),
        .accept_o  (filter_ok)
    );

`ifdef PKT_DEFRAMER_CHECKSUM_EN
    // Final word is the checksum; word 7 already sits in its shadow.
    assign final_ok      = filter_ok && (rx_data == csum_q);
    assign hops_ch_final = sh_hch_q;
`else
    // Final word is hopsFromCH itself and is taken straight from the bus.
    assign final_ok      = filter_ok;
    assign hops_ch_final = rx_data;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_type_d   = sh_type_q;
        sh_src_d    = sh_src_q;
        sh_energy_d = sh_energy_q;
        sh_qval_d   = sh_qval_q;
        sh_shops_d  = sh_shops_q;
        sh_dest_d   = sh_dest_q;
        sh_ch_d     = sh_ch_q;
`ifdef PKT_DEFRAMER_CHECKSUM_EN
        sh_hch_d    = sh_hch_q;
        csum_d      = csum_q;
`endif
        f_type_d    = f_type_q;
        f_src_d     = f_src_q;
        f_energy_d  = f_energy_q;
        f_qval_d    = f_qval_q;
        f_shops_d   = f_shops_q;
        f_dest_d    = f_dest_q;
        f_ch_d      = f_ch_q;
        f_hch_d     = f_hch_q;
        iam_d       = iam_q;
        drop_inc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Non-header words arriving here are silently discarded.
                if (xfer && rx_sof) begin
                    sh_type_d = rx_data[2:0];
`ifdef PKT_DEFRAMER_CHECKSUM_EN
                    csum_d    = rx_data;
`endif
                    cnt_d     = CNT_W'(1);
                    state_d   = S_RECV;
                end
            end

            S_RECV: begin
                if (!en) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (xfer && rx_sof) begin
                    // A new header aborts the current packet and restarts.
                    drop_inc  = 1'b1;
                    sh_type_d = rx_data[2:0];
`ifdef PKT_DEFRAMER_CHECKSUM_EN
                    csum_d    = rx_data;
`endif
                    cnt_d     = CNT_W'(1);
                end else if (xfer) begin
`ifdef PKT_DEFRAMER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    case (int'(cnt_q))
                        FLD_SOURCE:   sh_src_d    = rx_data;
                        FLD_ENERGY:   sh_energy_d = rx_data;
                        FLD_QVALUE:   sh_qval_d   = rx_data;
                        FLD_SRC_HOPS: sh_shops_d  = rx_data;
                        FLD_DEST:     sh_dest_d   = rx_data;
                        FLD_CH:       sh_ch_d     = rx_data;
`ifdef PKT_DEFRAMER_CHECKSUM_EN
                        FLD_HOPS_CH:  sh_hch_d    = rx_data;
`endif
                        default: ;
                    endcase

                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (final_ok) begin
                            f_type_d   = sh_type_q;
                            f_src_d    = sh_src_q;
                            f_energy_d = sh_energy_q;
                            f_qval_d   = sh_qval_q;
                            f_shops_d  = sh_shops_q;
                            f_dest_d   = sh_dest_q;
                            f_ch_d     = sh_ch_q;
                            f_hch_d    = hops_ch_final;
                            iam_d      = (sh_dest_q == myNodeID);
                            state_d    = S_HOLD;
                        end else begin
                            drop_inc = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_HOLD: begin
                // Enable does not affect a held packet; only the consumer does.
                if (pkt_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        drop_d = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_type_q   <= '0;
            sh_src_q    <= '0;
            sh_energy_q <= '0;
            sh_qval_q   <= '0;
            sh_shops_q  <= '0;
            sh_dest_q   <= '0;
            sh_ch_q     <= '0;
`ifdef PKT_DEFRAMER_CHECKSUM_EN
            sh_hch_q    <= '0;
            csum_q      <= '0;
`endif
            f_type_q    <= PT_INVALID;
            f_src_q     <= '0;
            f_energy_q  <= '0;
            f_qval_q    <= '0;
            f_shops_q   <= '0;
            f_dest_q    <= '0;
            f_ch_q      <= '0;
            f_hch_q     <= '0;
            iam_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_type_q   <= sh_type_d;
            sh_src_q    <= sh_src_d;
            sh_energy_q <= sh_energy_d;
            sh_qval_q   <= sh_qval_d;
            sh_shops_q  <= sh_shops_d;
            sh_dest_q   <= sh_dest_d;
            sh_ch_q     <= sh_ch_d;
`ifdef PKT_DEFRAMER_CHECKSUM_EN
            sh_hch_q    <= sh_hch_d;
            csum_q      <= csum_d;
`endif
            f_type_q    <= f_type_d;
            f_src_q     <= f_src_d;
            f_energy_q  <= f_energy_d;
            f_qval_q    <= f_qval_d;
            f_shops_q   <= f_shops_d;
            f_dest_q    <= f_dest_d;
            f_ch_q      <= f_ch_d;
            f_hch_q     <= f_hch_d;
            iam_q       <= iam_d;
            drop_q      <= drop_d;
        end
    end

    assign pkt_valid      = (state_q == S_HOLD);
    assign fPacketType    = f_type_q;
    assign fSourceID      = f_src_q;
    assign fEnergyLeft    = f_energy_q;
    assign fQValue        = f_qval_q;
    assign fSourceHops    = f_shops_q;
    assign fDestinationID = f_dest_q;
    assign fChosenCH      = f_ch_q;
    assign fHopsFromCH    = f_hch_q;
    assign iAmDestination = iam_q;
    assign drop_count     = drop_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_pkt_deframer.sv
// -----------------------------------------------------------------------------
// tb_pkt_deframer
// Self-checking bench for pkt_deframer: directed scenarios followed by random
// packets, compared against a rule-level reference model.
// -----------------------------------------------------------------------------
module tb_pkt_deframer;
    import pkt_pkg::*;

    localparam logic [15:0] MY_ID = 16'd5;
    localparam logic [15:0] BCAST = 16'hFFFF;

    logic        clk;
    logic        nrst;
    logic        en;
    logic [15:0] myNodeID;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_ready;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [2:0]  fPacketType;
    logic [15:0] fSourceID, fEnergyLeft, fQValue, fSourceHops;
    logic [15:0] fDestinationID, fChosenCH, fHopsFromCH;
    logic        iAmDestination;
    logic [7:0]  drop_count;
    logic [1:0]  dbg_state;

    pkt_deframer dut (
        .clk           (clk),
        .nrst          (nrst),
        .en            (en),
        .myNodeID      (myNodeID),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_sof        (rx_sof),
        .rx_ready      (rx_ready),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .fPacketType   (fPacketType),
        .fSourceID     (fSourceID),
        .fEnergyLeft   (fEnergyLeft),
        .fQValue       (fQValue),
        .fSourceHops   (fSourceHops),
        .fDestinationID(fDestinationID),
        .fChosenCH     (fChosenCH),
        .fHopsFromCH   (fHopsFromCH),
        .iAmDestination(iAmDestination),
        .drop_count    (drop_count),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_fail = 0;
    int          exp_drop = 0;
    logic [15:0] cur [0:8];        // packet being sent
    logic [15:0] last [0:7];       // fields of the last accepted packet
    logic [15:0] exp_q [$];        // expected field words of accepted packets

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_accept();
        int t;
        bit ok;
        t = int'(cur[0][2:0]);
        if (t <= 2)      ok = 1'b1;
        else if (t == 7) ok = 1'b0;
        else             ok = (cur[5] == MY_ID) || (cur[5] == BCAST);
`ifdef PKT_DEFRAMER_CHECKSUM_EN
        begin
            logic [15:0] x;
            x = '0;
            for (int i = 0; i < 8; i++) x = x ^ cur[i];
            if (x != cur[8]) ok = 1'b0;
        end
`endif
        return ok;
    endfunction

    function automatic int bump_drop(input int d);
        return (d < 255) ? d + 1 : 255;
    endfunction

    task automatic build_pkt(input logic [2:0] t, input logic [15:0] dest);
        cur[0] = (16'($urandom) & 16'hFFF8) | {13'd0, t};
        for (int i = 1; i < 8; i++) cur[i] = 16'($urandom);
        cur[5] = dest;
        cur[8] = '0;
        for (int i = 0; i < 8; i++) cur[8] = cur[8] ^ cur[i];
    endtask

    function automatic logic [15:0] rand_dest();
        int s;
        s = int'($urandom_range(0, 2));
        if (s == 0) return MY_ID;
        if (s == 1) return BCAST;
        return 16'($urandom);
    endfunction

    // ---------------- drivers ----------------
    task automatic send_word(input logic [15:0] d, input logic s, input int gap);
        int waited;
        waited = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = d;
        rx_sof   = s;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            check("rx_ready_timeout", rx_ready, 1);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            rx_sof   = 1'b0;
        end
    endtask

    task automatic send_words(input int first, input int count, input bit use_sof, input int max_gap);
        for (int i = first; i < first + count; i++)
            send_word(cur[i], use_sof && (i == 0), int'($urandom_range(0, max_gap)));
    endtask

    task automatic check_fields(input string tag);
        logic [15:0] e [0:7];
        if (exp_q.size() < 8) begin
            check({tag, "_queue_depth"}, exp_q.size(), 8);
        end else begin
            for (int i = 0; i < 8; i++) e[i] = exp_q.pop_front();
            check({tag, "_fPacketType"},    fPacketType,    e[0][2:0]);
            check({tag, "_fSourceID"},      fSourceID,      e[1]);
            check({tag, "_fEnergyLeft"},    fEnergyLeft,    e[2]);
            check({tag, "_fQValue"},        fQValue,        e[3]);
            check({tag, "_fSourceHops"},    fSourceHops,    e[4]);
            check({tag, "_fDestinationID"}, fDestinationID, e[5]);
            check({tag, "_fChosenCH"},      fChosenCH,      e[6]);
            check({tag, "_fHopsFromCH"},    fHopsFromCH,    e[7]);
        end
    endtask

    // Called right after the last word of a packet was transferred.
    task automatic finish_pkt(input string tag, input int hold_k, input bit rand_en);
        bit acc;
        acc = model_accept();
        @(negedge clk);
        if (acc) begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back(cur[i]);
                last[i] = cur[i];
            end
            check({tag, "_pkt_valid_latency"}, pkt_valid, 1);
            check_fields(tag);
            check({tag, "_iAmDestination"}, iAmDestination, (cur[5] == MY_ID));
            check({tag, "_drop_count"}, drop_count, exp_drop);
            pkt_ready = 1'b0;
            for (int k = 0; k < hold_k; k++) begin
                if (rand_en) en = 1'(($urandom_range(0, 1)));
                @(negedge clk);
                check({tag, "_hold_pkt_valid"},   pkt_valid,   1);
                check({tag, "_hold_fSourceID"},   fSourceID,   last[1]);
                check({tag, "_hold_fHopsFromCH"}, fHopsFromCH, last[7]);
                check({tag, "_hold_rx_ready"},    rx_ready,    0);
            end
            en        = 1'b1;
            pkt_ready = 1'b1;
            @(negedge clk);
            pkt_ready = 1'b0;
            check({tag, "_release_pkt_valid"}, pkt_valid, 0);
            check({tag, "_release_rx_ready"},  rx_ready,  1);
        end else begin
            exp_drop = bump_drop(exp_drop);
            check({tag, "_rej_pkt_valid"},   pkt_valid,   0);
            check({tag, "_rej_drop_count"},  drop_count,  exp_drop);
            check({tag, "_rej_fPacketType"}, fPacketType, last[0][2:0]);
            check({tag, "_rej_fSourceID"},   fSourceID,   last[1]);
            check({tag, "_rej_fDestID"},     fDestinationID, last[5]);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pkt_valid"},      pkt_valid,      0);
        check({tag, "_fPacketType"},    fPacketType,    3'b111);
        check({tag, "_fSourceID"},      fSourceID,      0);
        check({tag, "_fEnergyLeft"},    fEnergyLeft,    0);
        check({tag, "_fDestinationID"}, fDestinationID, 0);
        check({tag, "_fHopsFromCH"},    fHopsFromCH,    0);
        check({tag, "_iAmDestination"}, iAmDestination, 0);
        check({tag, "_drop_count"},     drop_count,     0);
        check({tag, "_rx_ready"},       rx_ready,       en);
        check({tag, "_state"},          dbg_state,      S_IDLE);
    endtask

    task automatic clear_last();
        last[0] = 16'd7;
        for (int i = 1; i < 8; i++) last[i] = '0;
        exp_drop = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        nrst      = 1'b0;
        en        = 1'b0;
        myNodeID  = MY_ID;
        rx_data   = '0;
        rx_valid  = 1'b0;
        rx_sof    = 1'b0;
        pkt_ready = 1'b0;
        clear_last();

        // Reset state, with enable low then high.
        repeat (2) @(negedge clk);
        check_reset_vals("reset_en0");
        en = 1'b1;
        #1;
        check_reset_vals("reset_en1");
        @(negedge clk);
        nrst = 1'b1;

        // HB broadcast from source 3, no stalls.
        build_pkt(3'b000, BCAST);
        cur[1] = 16'd3;
        send_words(0, PKT_WORDS, 1'b1, 0);
        finish_pkt("hb", 1, 1'b0);

        // DATA to this node, consumer stalls for 4 cycles.
        build_pkt(3'b101, MY_ID);
        send_words(0, PKT_WORDS, 1'b1, 0);
        finish_pkt("data_hold", 4, 1'b0);

        // DATA to another node is dropped.
        build_pkt(3'b101, 16'd9);
        send_words(0, PKT_WORDS, 1'b1, 0);
        finish_pkt("data_other", 0, 1'b0);

        // MR aborted after word 3 by a new header, then an INV packet.
        build_pkt(3'b011, MY_ID);
        send_words(0, 4, 1'b1, 0);
        exp_drop = bump_drop(exp_drop);
        build_pkt(3'b010, 16'h1234);
        send_words(0, PKT_WORDS, 1'b1, 0);
        finish_pkt("abort_inv", 2, 1'b0);

        // Enable drop mid-packet: abort without a drop; leftovers discarded.
        build_pkt(3'b110, MY_ID);
        send_words(0, 3, 1'b1, 0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_abort_state", dbg_state, S_IDLE);
        check("en_abort_rx_ready", rx_ready, 0);
        check("en_abort_drop", drop_count, exp_drop);
        en = 1'b1;
        send_words(3, PKT_WORDS - 3, 1'b0, 0);
        @(negedge clk);
        check("leftover_pkt_valid", pkt_valid, 0);
        check("leftover_state", dbg_state, S_IDLE);
        check("leftover_drop", drop_count, exp_drop);

        // Random packets: random types/destinations, gaps, junk, consumer stalls.
        for (int n = 0; n < 60; n++) begin
            build_pkt(3'($urandom_range(0, 7)), rand_dest());
`ifdef PKT_DEFRAMER_CHECKSUM_EN
            if ($urandom_range(0, 7) == 0) cur[8] = cur[8] ^ 16'h0001;
`endif
            repeat ($urandom_range(0, 2)) send_word(16'($urandom), 1'b0, 0);
            pkt_ready = 1'($urandom_range(0, 1));
            send_words(0, PKT_WORDS, 1'b1, 2);
            finish_pkt("rand", int'($urandom_range(0, 3)), 1'b1);
        end

        // Drop counter saturation: 257 invalid-type packets.
        for (int n = 0; n < 257; n++) begin
            build_pkt(3'b111, rand_dest());
            send_words(0, PKT_WORDS, 1'b1, 0);
            finish_pkt("sat", 0, 1'b0);
        end
        check("sat_drop_count_255", drop_count, 8'd255);

        // Reset while receiving word 5.
        build_pkt(3'b011, BCAST);
        send_words(0, 5, 1'b1, 0);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        clear_last();
        check_reset_vals("mid_reset");
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_pkt_valid", pkt_valid, 0);
        end
        send_words(5, PKT_WORDS - 5, 1'b0, 0);
        @(negedge clk);
        check("post_reset_leftover_valid", pkt_valid, 0);
        check("post_reset_fPacketType", fPacketType, 3'b111);
        build_pkt(3'b001, 16'h0042);
        send_words(0, PKT_WORDS, 1'b1, 1);
        finish_pkt("post_reset_che", 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_deframer.md
PKT_DEFRAMER -- requirements
Module: pkt_deframer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, width of every packet word and field.
REQ-002 SHALL have parameter BROADCAST_ID, default 16'hFFFF, destination ID matching all nodes.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports en  input  1  block enable; myNodeID  input  WORD_WIDTH  own node ID.
REQ-006 SHALL have ports rx_data  input  WORD_WIDTH  received word; rx_valid  input  1  word valid; rx_sof  input  1  word is header; rx_ready  output  1  word accepted.
REQ-007 SHALL have ports pkt_valid  output  1  parsed packet available; pkt_ready  input  1  consumer accepts packet.
REQ-008 SHALL have outputs fPacketType (3), fSourceID, fEnergyLeft, fQValue, fSourceHops, fDestinationID, fChosenCH, fHopsFromCH (WORD_WIDTH each): parsed fields.
REQ-009 SHALL have outputs iAmDestination  1  fDestinationID equals myNodeID; drop_count  8  dropped-packet counter.

Function
REQ-010 Packet SHALL be 8 words: header (type in bits [2:0], other bits ignored), sourceID, energyLeft, QValue, sourceHops, destinationID, chosenCH, hopsFromCH.
REQ-011 Word transfer SHALL occur only when rx_valid && rx_ready.
REQ-012 rx_ready SHALL be 1 when en=1 and state is not S_HOLD; 0 otherwise.
REQ-013 States SHALL be S_IDLE, S_RECV, S_HOLD.
REQ-014 S_IDLE: transfer with rx_sof=1 SHALL capture header, set word counter to 1, go to S_RECV; transfers with rx_sof=0 SHALL be discarded without counting.
REQ-015 S_RECV: each transfer SHALL store the word into the field selected by a 3-bit counter, then increment the counter.
REQ-016 Transfer with rx_sof=1 in S_RECV SHALL abort the current packet, increment drop_count, and restart with that word as the header.
REQ-017 On transfer of word 7, the accept decision SHALL be evaluated on the received fields and word 7.
REQ-018 Accept: type in {000 HB, 001 CHE, 010 INV} always; type in {011, 100, 101, 110} only if destination equals myNodeID or BROADCAST_ID; type 111 never.
REQ-019 Accepted: next cycle S_HOLD, pkt_valid=1, fields and iAmDestination stable; latency from last word to pkt_valid is exactly 1 cycle.
REQ-020 Rejected: return to S_IDLE, pkt_valid stays 0, drop_count increments.
REQ-021 S_HOLD: pkt_valid SHALL remain 1 and the fields SHALL hold until pkt_ready=1; then pkt_valid=0 and state S_IDLE on the next cycle.
REQ-022 pkt_ready while pkt_valid=0 SHALL have no effect.
REQ-023 en=0 in S_RECV SHALL abort to S_IDLE without incrementing drop_count; en=0 in S_HOLD SHALL NOT clear the held packet.
REQ-024 drop_count SHALL saturate at 255.
REQ-025 Field outputs SHALL update only on acceptance (REQ-019); words of an in-progress packet SHALL go to shadow registers.

Reset
REQ-026 On nrst=0: state S_IDLE, counter 0, pkt_valid 0, fPacketType 3'b111, all field outputs 0, iAmDestination 0, drop_count 0; rx_ready follows REQ-012.
REQ-027 Reset during S_RECV or S_HOLD SHALL discard the packet, with no pkt_valid pulse after release.

Configuration
REQ-028 Macro PKT_DEFRAMER_CHECKSUM_EN defined: the packet SHALL be 9 words, word 8 being the XOR of words 0-7; a mismatch SHALL reject the packet (REQ-020); the REQ-017 decision SHALL move to word 8.
REQ-029 Macro PKT_DEFRAMER_CHECKSUM_EN undefined: 8-word packets per REQ-010 and no checksum logic.

Structure
REQ-030 Shared package pkt_pkg SHALL hold: packet-type enum (HB..SOS, INVALID=111), PKT_WORDS, BROADCAST_ID default, and field-index constants shared with the packet packer.
REQ-031 Accept logic (REQ-018) SHALL be a combinational sub-module pkt_accept_filter.

Verification
REQ-032 myNodeID=5; HB packet, source 3, dest FFFF, no stalls -> pkt_valid 1 cycle after word 7; fPacketType=000; fSourceID=3; iAmDestination=0.
REQ-033 myNodeID=5; Data (101) with dest 5; pkt_ready held low 4 cycles -> pkt_valid and fields stable 4 cycles; rx_ready=0 throughout; iAmDestination=1.
REQ-034 myNodeID=5; Data with dest 9 -> no pkt_valid; drop_count 0->1.
REQ-035 rx_sof after word 3 of an MR packet, then a complete INV packet -> drop_count +1; INV delivered with fPacketType=010.
REQ-036 256 rejected type-111 packets, then one more -> drop_count stays 255.
REQ-037 nrst asserted at word 5, then released -> outputs at reset values; no pkt_valid until a new full packet arrives.
